// File: rtl/ds18b20_pkg.sv
// ds18b20_pkg: shared poll-scheduler state encoding, ms-tick helper and DS18B20 command/timing constants.
package ds18b20_pkg;
  typedef enum logic [2:0] {IDLE, SETTLE, KICK, WAIT_RD, WAIT_DONE, WAIT_PER} pollState_t;
  localparam int MS_PER_S = 1000;
  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT_T = 8'h44;
  localparam logic [7:0] CMD_READ_SCRATCH = 8'hBE;
  localparam int CONV_MS_12BIT = 750;
  localparam int SCRATCH_BYTES = 9;
  function automatic int msTicks(input int clkHz);
    return clkHz / MS_PER_S;
  endfunction
endpackage

// File: rtl/temp_avg_filt.sv
// temp_avg_filt: power-of-two moving average of accepted temperature samples.
// The first sample after reset preloads the whole history so the average starts settled.
module temp_avg_filt #(
  parameter int AVG_LOG2 = 2
) (
  input  logic       CLK_10MHZ,
  input  logic       rst,
  input  logic       sampleVld,
  input  logic [8:0] sample,
  output logic [8:0] tempAvg,
  output logic       tempValid,
  output logic       avgRdy
);
  localparam int D = 1 << AVG_LOG2;
  localparam int SW = 9 + AVG_LOG2;
  logic [8:0] hist [D];
  logic [SW-1:0] sum;
  logic [AVG_LOG2-1:0] ptr;
  logic primed, vld1;
  always_ff @(posedge CLK_10MHZ or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < D; i++) hist[i] <= '0;
      sum <= '0;
      ptr <= '0;
      primed <= 1'b0;
      vld1 <= 1'b0;
      avgRdy <= 1'b0;
      tempValid <= 1'b0;
      tempAvg <= '0;
    end else begin
      vld1 <= sampleVld;
      avgRdy <= vld1;
      tempValid <= avgRdy;
      if (vld1) tempAvg <= sum[SW-1:AVG_LOG2];
      if (sampleVld) begin
        primed <= 1'b1;
        sum <= primed ? sum + SW'(sample) - SW'(hist[ptr]) : {sample, AVG_LOG2'(0)};
        for (int i = 0; i < D; i++) if (!primed || AVG_LOG2'(i) == ptr) hist[i] <= sample;
        ptr <= primed ? ptr + 1'b1 : '0;
      end
    end
  end
endmodule

// File: rtl/ds18b20_poll_sched.sv
// ds18b20_poll_sched: periodic DS18B20 poll scheduler with stale-read discard,
// moving average, hysteresis alarm and timeout fault tracking.
module ds18b20_poll_sched
  import ds18b20_pkg::*;
#(
  parameter int CLK_HZ = 10000000,
  parameter int PERIOD_MS = 1000,
  parameter int CONV_MS = 750,
  parameter int TIMEOUT_MS = 50,
  parameter int AVG_LOG2 = 2
) (
  input  logic       CLK_10MHZ,
  input  logic       rst,
  input  logic       enable,
  output logic       start,
  input  logic       readState,
  input  logic [8:0] temperature,
  input  logic [8:0] thr_hi,
  input  logic [8:0] thr_lo,
  output logic [8:0] temp_avg,
  output logic       temp_valid,
  output logic       alarm,
  output logic       sensor_fault,
  output logic [3:0] fault_cnt
);
  localparam int TICK = msTicks(CLK_HZ);
  localparam int PER_CYC = PERIOD_MS * TICK;
  localparam int TO_CYC = TIMEOUT_MS * TICK;
  localparam int PW = $clog2(TICK);
  localparam int MW = $clog2(CONV_MS + 1);
  localparam int KW = $clog2(PER_CYC);
  pollState_t state, nextState;
  logic [PW-1:0] preCnt;
  logic [MW-1:0] msCnt;
  logic [KW-1:0] kickCnt;
  logic readStateD, discard, tick, fall, capture, timeout, avgRdy;
  assign tick = preCnt == PW'(TICK - 1);
  assign fall = readStateD && !readState;
  always_comb begin
    nextState = IDLE;
    start = 1'b0;
    capture = 1'b0;
    timeout = 1'b0;
    if (enable)
      case (state)
        IDLE: nextState = SETTLE;
        SETTLE: nextState = (tick && msCnt == MW'(CONV_MS - 1)) ? KICK : SETTLE;
        KICK: begin
          start = 1'b1;
          nextState = WAIT_RD;
        end
        WAIT_RD: begin
          timeout = !readState && kickCnt == KW'(TO_CYC - 1);
          nextState = readState ? WAIT_DONE : timeout ? WAIT_PER : WAIT_RD;
        end
        WAIT_DONE: begin
          capture = fall;
          nextState = fall ? WAIT_PER : WAIT_DONE;
        end
        WAIT_PER: nextState = (kickCnt == KW'(PER_CYC - 1)) ? KICK : WAIT_PER;
        default: nextState = IDLE;
      endcase
  end
  // kickCnt runs from the KICK cycle across the intermediate states, so the
  // start-to-start period is unaffected by when the read finishes.
  always_ff @(posedge CLK_10MHZ or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      preCnt <= '0;
      msCnt <= '0;
      kickCnt <= '0;
      readStateD <= 1'b0;
      discard <= 1'b1;
      alarm <= 1'b0;
      sensor_fault <= 1'b0;
      fault_cnt <= '0;
    end else begin
      state <= nextState;
      preCnt <= (nextState != state || tick || !enable) ? '0 : preCnt + 1'b1;
      msCnt <= (nextState != state) ? '0 : msCnt + MW'(tick);
      kickCnt <= (state == KICK) ? KW'(1) : kickCnt + KW'(kickCnt != KW'(PER_CYC - 1));
      readStateD <= readState;
      discard <= (state == IDLE) ? 1'b1 : capture ? 1'b0 : discard;
      sensor_fault <= timeout ? 1'b1 : capture ? 1'b0 : sensor_fault;
      fault_cnt <= timeout ? fault_cnt + 4'(fault_cnt != 4'hF) : fault_cnt;
      if (avgRdy) alarm <= (temp_avg >= thr_hi) ? 1'b1 : (temp_avg <= thr_lo) ? 1'b0 : alarm;
    end
  end
  temp_avg_filt #(.AVG_LOG2(AVG_LOG2)) u_filt (
    .CLK_10MHZ(CLK_10MHZ),
    .rst(rst),
    .sampleVld(capture && !discard),
    .sample(temperature),
    .tempAvg(temp_avg),
    .tempValid(temp_valid),
    .avgRdy(avgRdy)
  );
endmodule

// File: tb/tb_ds18b20_poll_sched.sv
// tb_ds18b20_poll_sched: randomized controller model and queue-based averaging/alarm reference for ds18b20_poll_sched.
module tb_ds18b20_poll_sched;
  localparam int DEPTH = 4;
  logic CLK_10MHZ = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic readState = 1'b0;
  logic [8:0] temperature = '0;
  logic [8:0] thr_hi = '0;
  logic [8:0] thr_lo = '0;
  logic start, temp_valid, alarm, sensor_fault;
  logic [8:0] temp_avg;
  logic [3:0] fault_cnt;
  int vectors = 0, errors = 0, edgeN = 0, fallEdge = 0, fallCount = 0, validCount = 0, answer = 0;
  int q[$];
  int mHist[$];
  int startEdges[$];
  logic mAlarm = 1'b0;
  int mAvg = 0;

  ds18b20_poll_sched #(.CLK_HZ(10000), .PERIOD_MS(10), .CONV_MS(5), .TIMEOUT_MS(2), .AVG_LOG2(2)) dut (
    .CLK_10MHZ(CLK_10MHZ), .rst(rst), .enable(enable), .start(start), .readState(readState),
    .temperature(temperature), .thr_hi(thr_hi), .thr_lo(thr_lo), .temp_avg(temp_avg),
    .temp_valid(temp_valid), .alarm(alarm), .sensor_fault(sensor_fault), .fault_cnt(fault_cnt)
  );

  always #5 CLK_10MHZ = ~CLK_10MHZ;
  always @(posedge CLK_10MHZ) edgeN <= edgeN + 1;
  always @(posedge CLK_10MHZ) begin
    #1;
    if (start) startEdges.push_back(edgeN);
    if (temp_valid) validCount++;
  end

  // Controller model: answers a start with a readState burst, result valid as readState falls.
  initial begin
    forever begin
      @(posedge CLK_10MHZ); #1;
      if (start && answer != 0 && q.size() > 0) begin
        repeat ($urandom_range(0, 6)) begin @(posedge CLK_10MHZ); #1; end
        readState = 1'b1;
        temperature = 9'($urandom);
        repeat ($urandom_range(2, 8)) begin @(posedge CLK_10MHZ); #1; end
        temperature = 9'(q.pop_front());
        readState = 1'b0;
        fallEdge = edgeN;
        fallCount++;
      end
    end
  end

  function automatic int modelPush(input int v);
    int s = 0;
    if (mHist.size() == 0) repeat (DEPTH) mHist.push_back(v);
    else begin
      void'(mHist.pop_front());
      mHist.push_back(v);
    end
    foreach (mHist[i]) s += mHist[i];
    return s / DEPTH;
  endfunction

  function automatic logic alarmNext(input int avg, input int hi, input int lo, input logic cur);
    return (avg >= hi) ? 1'b1 : (avg <= lo) ? 1'b0 : cur;
  endfunction

  task automatic waitValid(input int budget, output bit got);
    got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge CLK_10MHZ); #1;
      got = temp_valid;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(posedge CLK_10MHZ);
    #1;
    vectors++; if (temp_avg !== 9'd0) begin errors++; $display("FAIL reset_temp_avg: got %0d want 0", temp_avg); end
    vectors++; if (temp_valid !== 1'b0) begin errors++; $display("FAIL reset_temp_valid: got %b want 0", temp_valid); end
    vectors++; if (alarm !== 1'b0) begin errors++; $display("FAIL reset_alarm: got %b want 0", alarm); end
    vectors++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL reset_fault: got %b want 0", sensor_fault); end
    vectors++; if (fault_cnt !== 4'd0) begin errors++; $display("FAIL reset_fault_cnt: got %0d want 0", fault_cnt); end
    vectors++; if (start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", start); end
    @(negedge CLK_10MHZ); rst = 1'b0;
  endtask

  task automatic test_basic();
    int enEdge;
    bit got;
    int samples[3] = '{20, 20, 24};
    thr_hi = 9'd100;
    thr_lo = 9'd10;
    answer = 1;
    q = '{85, 20, 20, 24};
    startEdges.delete();
    validCount = 0;
    @(negedge CLK_10MHZ); enable = 1'b1; enEdge = edgeN + 1;
    for (int k = 0; k < 3; k++) begin
      waitValid(400, got);
      mAvg = modelPush(samples[k]);
      mAlarm = alarmNext(mAvg, thr_hi, thr_lo, mAlarm);
      vectors++;
      if (!got) begin errors++; $display("FAIL basic_valid[%0d]: no temp_valid, want a pulse", k); end
      else begin
        vectors++; if (temp_avg !== 9'(mAvg)) begin errors++; $display("FAIL basic_avg[%0d]: got %0d want %0d", k, temp_avg, mAvg); end
        vectors++; if (edgeN - fallEdge != 3) begin errors++; $display("FAIL basic_valid_lat[%0d]: got %0d edges want 3", k, edgeN - fallEdge); end
      end
    end
    @(posedge CLK_10MHZ); #2;
    vectors++; if (validCount != 3) begin errors++; $display("FAIL basic_valid_cnt: got %0d want 3", validCount); end
    vectors++; if (alarm !== mAlarm) begin errors++; $display("FAIL basic_alarm: got %b want %b", alarm, mAlarm); end
    vectors++;
    if (startEdges.size() < 4) begin errors++; $display("FAIL basic_starts: got %0d starts want 4", startEdges.size()); end
    else begin
      vectors++; if (startEdges[0] - enEdge != 50) begin errors++; $display("FAIL first_start: got %0d edges want 50", startEdges[0] - enEdge); end
      for (int i = 1; i < 4; i++) begin
        vectors++; if (startEdges[i] - startEdges[i-1] != 100) begin errors++; $display("FAIL start_period[%0d]: got %0d want 100", i, startEdges[i] - startEdges[i-1]); end
      end
    end
  endtask

  task automatic test_enable_drop();
    int n;
    @(negedge CLK_10MHZ); enable = 1'b0; n = startEdges.size();
    repeat (300) @(posedge CLK_10MHZ);
    #2;
    vectors++; if (startEdges.size() != n) begin errors++; $display("FAIL drop_starts: got %0d extra starts want 0", startEdges.size() - n); end
    vectors++; if (temp_avg !== 9'(mAvg)) begin errors++; $display("FAIL drop_hold_avg: got %0d want %0d", temp_avg, mAvg); end
    vectors++; if (alarm !== mAlarm) begin errors++; $display("FAIL drop_hold_alarm: got %b want %b", alarm, mAlarm); end
  endtask

  task automatic test_timeout();
    int s, fc, vc;
    bit ok;
    answer = 0;
    @(negedge CLK_10MHZ); enable = 1'b1;
    for (int k = 0; k < 17; k++) begin
      ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
        @(posedge CLK_10MHZ); #1;
        if (start) begin ok = 1'b1; s = edgeN; end
      end
      vectors++;
      if (!ok) begin errors++; $display("FAIL to_start[%0d]: no start, want one", k); end
      else begin
        repeat (19) @(posedge CLK_10MHZ);
        #1;
        vectors++; if (sensor_fault !== (k > 0)) begin errors++; $display("FAIL to_early[%0d]: fault %b want %b at +19", k, sensor_fault, k > 0); end
        @(posedge CLK_10MHZ); #1;
        vectors++;
        if (sensor_fault !== 1'b1 || fault_cnt !== 4'(k < 15 ? k + 1 : 15)) begin
          errors++; $display("FAIL to_fault[%0d]: fault %b cnt %0d want 1 cnt %0d", k, sensor_fault, fault_cnt, k < 15 ? k + 1 : 15);
        end
      end
    end
    fc = fallCount;
    vc = validCount;
    q.push_back(123);
    answer = 1;
    for (int i = 0; i < 300 && fallCount == fc; i++) @(posedge CLK_10MHZ);
    repeat (4) @(posedge CLK_10MHZ);
    #2;
    vectors++; if (sensor_fault !== 1'b0) begin errors++; $display("FAIL fault_clear: got %b want 0", sensor_fault); end
    vectors++; if (fault_cnt !== 4'd15) begin errors++; $display("FAIL fault_cnt_hold: got %0d want 15", fault_cnt); end
    vectors++; if (validCount != vc) begin errors++; $display("FAIL reenable_discard: got %0d pulses want 0", validCount - vc); end
    @(negedge CLK_10MHZ); enable = 1'b0;
  endtask

  task automatic test_alarm();
    bit got;
    int samples[9] = '{31, 31, 31, 31, 26, 26, 24, 24, 60};
    @(negedge CLK_10MHZ); rst = 1'b1;
    @(negedge CLK_10MHZ); rst = 1'b0;
    mHist.delete();
    mAlarm = 1'b0;
    vectors++; if (fault_cnt !== 4'd0) begin errors++; $display("FAIL alarm_rst_cnt: got %0d want 0", fault_cnt); end
    thr_hi = 9'd30;
    thr_lo = 9'd25;
    q = '{85};
    foreach (samples[i]) q.push_back(samples[i]);
    answer = 1;
    @(negedge CLK_10MHZ); enable = 1'b1;
    foreach (samples[k]) begin
      waitValid(400, got);
      mAvg = modelPush(samples[k]);
      mAlarm = alarmNext(mAvg, thr_hi, thr_lo, mAlarm);
      vectors++;
      if (!got) begin errors++; $display("FAIL alarm_valid[%0d]: no temp_valid, want a pulse", k); end
      else begin
        vectors++; if (temp_avg !== 9'(mAvg)) begin errors++; $display("FAIL alarm_avg[%0d]: got %0d want %0d", k, temp_avg, mAvg); end
        vectors++; if (alarm !== mAlarm) begin errors++; $display("FAIL alarm_flag[%0d]: got %b want %b (avg %0d)", k, alarm, mAlarm, mAvg); end
      end
    end
  endtask

  task automatic test_rst_midop();
    bit got;
    int relEdge, s;
    int samples[2] = '{40, 44};
    q.push_back(77);
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin @(posedge CLK_10MHZ); #1; got = readState; end
    vectors++;
    if (!got) begin errors++; $display("FAIL rst_wait_rd: readState never rose, want rise"); end
    @(posedge CLK_10MHZ); #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (temp_avg !== 9'd0 || temp_valid !== 1'b0 || alarm !== 1'b0 || sensor_fault !== 1'b0 || fault_cnt !== 4'd0 || start !== 1'b0) begin
      errors++; $display("FAIL rst_async: avg %0d valid %b alarm %b fault %b cnt %0d start %b want all 0", temp_avg, temp_valid, alarm, sensor_fault, fault_cnt, start);
    end
    mHist.delete();
    mAlarm = 1'b0;
    @(negedge CLK_10MHZ); rst = 1'b0; relEdge = edgeN + 1;
    q.push_back(99);
    foreach (samples[i]) q.push_back(samples[i]);
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin @(posedge CLK_10MHZ); #1; got = start; s = edgeN; end
    vectors++;
    if (!got || s - relEdge != 50) begin errors++; $display("FAIL rst_resettle: start at %0d edges want 50", got ? s - relEdge : -1); end
    foreach (samples[k]) begin
      waitValid(400, got);
      mAvg = modelPush(samples[k]);
      mAlarm = alarmNext(mAvg, thr_hi, thr_lo, mAlarm);
      vectors++;
      if (!got || temp_avg !== 9'(mAvg)) begin errors++; $display("FAIL rst_discard[%0d]: valid %b avg %0d want 1 avg %0d", k, got, temp_avg, mAvg); end
    end
  endtask

  task automatic test_random();
    bit got;
    int v;
    for (int k = 0; k < 10; k++) begin
      thr_hi = 9'($urandom_range(0, 511));
      thr_lo = 9'($urandom_range(0, 511));
      v = $urandom_range(0, 511);
      q.push_back(v);
      waitValid(400, got);
      mAvg = modelPush(v);
      mAlarm = alarmNext(mAvg, thr_hi, thr_lo, mAlarm);
      vectors++;
      if (!got) begin errors++; $display("FAIL rand_valid[%0d]: no temp_valid, want a pulse", k); end
      else begin
        vectors++; if (temp_avg !== 9'(mAvg)) begin errors++; $display("FAIL rand_avg[%0d]: got %0d want %0d", k, temp_avg, mAvg); end
        vectors++; if (alarm !== mAlarm) begin errors++; $display("FAIL rand_alarm[%0d]: got %b want %b (avg %0d hi %0d lo %0d)", k, alarm, mAlarm, mAvg, thr_hi, thr_lo); end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_enable_drop();
    test_timeout();
    test_alarm();
    test_rst_midop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
